// File: rtl/data_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_arbiter_pkg
// Purpose  : Shared types and constants for the data RAM port-A arbiter:
//            FSM state encoding, owner codes, RAM data width.
// Revision : 1.0 - initial release
// ============================================================================
package data_ram_arbiter_pkg;

  // RAM data width
  localparam int DATA_W = 32;

  // Arbiter states; values double as the owner code
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  // Owner codes presented on the owner output
  localparam logic [1:0] OWNER_IDLE = 2'd0;
  localparam logic [1:0] OWNER_M0   = 2'd1;
  localparam logic [1:0] OWNER_M1   = 2'd2;

  // Map an arbiter state onto its owner code
  function automatic logic [1:0] owner_code(input arb_state_t s);
    case (s)
      ST_OWN0: owner_code = OWNER_M0;
      ST_OWN1: owner_code = OWNER_M1;
      default: owner_code = OWNER_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram_arbiter_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_sat_counter
// Purpose  : 32-bit saturating event counter with increment enable, used for
//            the arbiter statistics. Only compiled when ARB_STATS_EN is
//            defined, so a default build carries no unused module.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef ARB_STATS_EN
module arb_sat_counter
  import data_ram_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_inc,
  output logic [DATA_W-1:0] o_count
);

  logic [DATA_W-1:0] r_count;

  // Count enabled events, sticking at all-ones
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + DATA_W'(1);
    end
  end

  assign o_count = r_count;

endmodule
`endif
`default_nettype wire

// File: rtl/data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_arbiter
// Purpose  : Round-robin arbiter sharing data RAM port A between M0 (datapath)
//            and M1 (debug/LCD). Supports locked bursts bounded by MAX_BURST
//            while the other master waits, byte-to-word address translation
//            and one-cycle read return with a valid strobe.
// Options  : ARB_STATS_EN - enables the stat_gnt0/stat_gnt1/stat_wait
//            saturating counters; otherwise the stat outputs are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              resetn,
  // master 0
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic [3:0]        m0_wen,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  // master 1
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic [3:0]        m1_wen,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  // RAM port A
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta,
  // status
  output logic [1:0]        owner,
  output logic [31:0]       stat_gnt0,
  output logic [31:0]       stat_gnt1,
  output logic [31:0]       stat_wait
);

  localparam int                BEAT_W    = $clog2(MAX_BURST);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  arb_state_t        r_state;
  logic              r_rr_ptr;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [1:0]        r_rd_pend;
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_last_din;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer0;
  logic              w_xfer1;
  logic              w_rd0;
  logic              w_rd1;
  logic [ADDR_W-1:0] w_waddr0;
  logic [ADDR_W-1:0] w_waddr1;

  // Byte address bits outside the word-address window are intentionally unused
  logic w_unused_addr;
  assign w_unused_addr = ^{m0_addr[1:0], m0_addr[31:ADDR_W+2],
                           m1_addr[1:0], m1_addr[31:ADDR_W+2]};

  assign w_waddr0 = m0_addr[ADDR_W+1:2];
  assign w_waddr1 = m1_addr[ADDR_W+1:2];

  // Grant decode: round-robin in IDLE, exclusive to the owner in OWNx.
  // Gated by resetn so grants drop the instant reset is asserted.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (resetn) begin
      case (r_state)
        ST_IDLE: begin
          w_gnt0 = m0_req && (!m1_req || !r_rr_ptr);
          w_gnt1 = m1_req && (!m0_req ||  r_rr_ptr);
        end
        ST_OWN0: w_gnt0 = m0_req;
        ST_OWN1: w_gnt1 = m1_req;
        default: begin
          w_gnt0 = 1'b0;
          w_gnt1 = 1'b0;
        end
      endcase
    end
  end

  assign m0_gnt  = w_gnt0;
  assign m1_gnt  = w_gnt1;
  assign w_xfer0 = m0_req && w_gnt0;
  assign w_xfer1 = m1_req && w_gnt1;
  assign w_rd0   = w_xfer0 && (m0_wen == 4'b0000);
  assign w_rd1   = w_xfer1 && (m1_wen == 4'b0000);

  // Ownership FSM with round-robin pointer and bounded burst counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer0) begin
            r_rr_ptr <= 1'b1;
            if (m0_lock) begin
              r_state    <= ST_OWN0;
              r_beat_cnt <= BEAT_ONE;
            end
          end else if (w_xfer1) begin
            r_rr_ptr <= 1'b0;
            if (m1_lock) begin
              r_state    <= ST_OWN1;
              r_beat_cnt <= BEAT_ONE;
            end
          end
        end
        ST_OWN0: begin
          if (w_xfer0) begin
            r_rr_ptr <= 1'b1;
            if (!m0_lock || ((r_beat_cnt == BEAT_LAST) && m1_req)) begin
              r_state    <= ST_IDLE;
              r_beat_cnt <= '0;
            end else if (r_beat_cnt != BEAT_LAST) begin
              r_beat_cnt <= r_beat_cnt + BEAT_ONE;
            end
          end else begin
            // owner dropped its request: release the port
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
          end
        end
        ST_OWN1: begin
          if (w_xfer1) begin
            r_rr_ptr <= 1'b0;
            if (!m1_lock || ((r_beat_cnt == BEAT_LAST) && m0_req)) begin
              r_state    <= ST_IDLE;
              r_beat_cnt <= '0;
            end else if (r_beat_cnt != BEAT_LAST) begin
              r_beat_cnt <= r_beat_cnt + BEAT_ONE;
            end
          end else begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_beat_cnt <= '0;
        end
      endcase
    end
  end

  // RAM port A mux; when nothing is granted keep address/data stable, no write
  always_comb begin
    ram_wea   = 4'b0000;
    ram_addra = r_last_addr;
    ram_dina  = r_last_din;
    if (w_gnt0) begin
      ram_wea   = m0_wen;
      ram_addra = w_waddr0;
      ram_dina  = m0_wdata;
    end else if (w_gnt1) begin
      ram_wea   = m1_wen;
      ram_addra = w_waddr1;
      ram_dina  = m1_wdata;
    end
  end

  // Remember the last granted address/data for the idle hold value
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_addr <= '0;
      r_last_din  <= '0;
    end else if (w_xfer0) begin
      r_last_addr <= w_waddr0;
      r_last_din  <= m0_wdata;
    end else if (w_xfer1) begin
      r_last_addr <= w_waddr1;
      r_last_din  <= m1_wdata;
    end
  end

  // Track which master's read data appears on ram_douta next cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_pend <= 2'b00;
    end else begin
      r_rd_pend <= {w_rd1, w_rd0};
    end
  end

  assign m0_rvalid = r_rd_pend[0];
  assign m1_rvalid = r_rd_pend[1];
  assign m0_rdata  = r_rd_pend[0] ? ram_douta : '0;
  assign m1_rdata  = r_rd_pend[1] ? ram_douta : '0;
  assign owner     = owner_code(r_state);

`ifdef ARB_STATS_EN
  // A cycle counts as waiting when any requester is left without a grant
  logic w_wait;
  assign w_wait = (m0_req && !w_gnt0) || (m1_req && !w_gnt1);

  arb_sat_counter u_stat_gnt0 (
    .clk     (clk),
    .resetn  (resetn),
    .i_inc   (w_xfer0),
    .o_count (stat_gnt0)
  );

  arb_sat_counter u_stat_gnt1 (
    .clk     (clk),
    .resetn  (resetn),
    .i_inc   (w_xfer1),
    .o_count (stat_gnt1)
  );

  arb_sat_counter u_stat_wait (
    .clk     (clk),
    .resetn  (resetn),
    .i_inc   (w_wait),
    .o_count (stat_wait)
  );
`else
  assign stat_gnt0 = '0;
  assign stat_gnt1 = '0;
  assign stat_wait = '0;
`endif

endmodule
`default_nettype wire
